// File: rtl/mux8_4to1_rr_pkg.sv
// ============================================================================
// Module      : mux8_4to1_rr_pkg
// Description : Sel codes and default width shared with the 1-to-4 byte demux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux8_4to1_rr_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_W = 2'b00;
    localparam sel_t SEL_X = 2'b01;
    localparam sel_t SEL_Y = 2'b10;
    localparam sel_t SEL_Z = 2'b11;

    function automatic sel_t sel_inc(input sel_t s);
        return s + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux8_4to1_rr_arb4_rr.sv
// ============================================================================
// Module      : arb4_rr
// Description : 4-way arbiter; round-robin with MUX8_4TO1_RR_EN, else fixed
//               priority (lowest code wins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb4_rr
    import mux8_4to1_rr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_vld
);

`ifdef MUX8_4TO1_RR_EN
    logic [1:0] r_ptr;
    logic [1:0] w_idx;

    // Scan from the farthest offset down so the one nearest ptr wins.
    always_comb begin
        gnt     = r_ptr;
        gnt_vld = 1'b0;
        w_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) begin
                gnt     = w_idx;
                gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= SEL_W;
        end else if (en && gnt_vld) begin
            r_ptr <= sel_inc(gnt);
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{clk, rst, en};

    always_comb begin
        gnt     = SEL_W;
        gnt_vld = |req;
        if (req[0])      gnt = SEL_W;
        else if (req[1]) gnt = SEL_X;
        else if (req[2]) gnt = SEL_Y;
        else if (req[3]) gnt = SEL_Z;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mux8_4to1_rr.sv
// ============================================================================
// Module      : mux8_4to1_rr
// Description : Registered 4-to-1 merger with Sel tagging; arbitration mode
//               selected by MUX8_4TO1_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux8_4to1_rr
    import mux8_4to1_rr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] W,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] Z,
    input  logic             Wv,
    input  logic             Xv,
    input  logic             Yv,
    input  logic             Zv,
    output logic             Wr,
    output logic             Xr,
    output logic             Yr,
    output logic             Zr,
    output logic [WIDTH-1:0] A,
    output logic [1:0]       Sel,
    output logic             Av,
    input  logic             Ar
);

    logic [WIDTH-1:0] r_a;
    logic [1:0]       r_sel;
    logic             r_av;

    logic             w_ld;
    logic [3:0]       w_req;
    logic [1:0]       w_gnt;
    logic             w_gnt_vld;
    logic             w_xfer;
    logic [3:0]       w_rdy;
    logic [WIDTH-1:0] w_data;

    assign w_ld   = !r_av || Ar;
    assign w_req  = {Zv, Yv, Xv, Wv};
    assign w_xfer = w_gnt_vld && w_ld;

    arb4_rr u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .en      (w_ld),
        .gnt     (w_gnt),
        .gnt_vld (w_gnt_vld)
    );

    // Gating with rst keeps producers from seeing a ready on a reset edge.
    assign w_rdy = (w_xfer && !rst) ? (4'b0001 << w_gnt) : 4'b0000;
    assign Wr    = w_rdy[0];
    assign Xr    = w_rdy[1];
    assign Yr    = w_rdy[2];
    assign Zr    = w_rdy[3];

    always_comb begin
        w_data = W;
        case (w_gnt)
            SEL_W:   w_data = W;
            SEL_X:   w_data = X;
            SEL_Y:   w_data = Y;
            default: w_data = Z;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_sel <= SEL_W;
            r_av  <= 1'b0;
        end else if (w_xfer) begin
            r_a   <= w_data;
            r_sel <= w_gnt;
            r_av  <= 1'b1;
        end else if (Ar) begin
            r_av  <= 1'b0;
        end
    end

    assign A   = r_a;
    assign Sel = r_sel;
    assign Av  = r_av;

endmodule

`default_nettype wire

// File: doc/mux8_4to1_rr.md
# mux8_4to1_rr

Registered 4-to-1 merger for 8-bit channels. It is the return path for the 1-to-4 byte demultiplexer: four producer channels (W, X, Y, Z) are arbitrated onto one output stream (A), and each output byte is tagged with the 2-bit Sel code of its source channel. Each input and the output use a valid/ready handshake. The output is a single registered stage.

## Interface
Parameters:
- WIDTH, default 8: data width of every channel.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- W, X, Y, Z  input  WIDTH each  channel data; the Sel codes are 00, 01, 10, 11 respectively.
- Wv, Xv, Yv, Zv  input  1 each  channel valid.
- Wr, Xr, Yr, Zr  output  1 each  channel ready (combinational).
- A  output  WIDTH  merged data (registered).
- Sel  output  2  source code of the byte on A (registered).
- Av  output  1  output valid (registered).
- Ar  input  1  downstream ready.

## Operation
- Transfer rules:
  - A channel transfer occurs when its valid and ready are both high on a rising edge.
  - An output transfer occurs when Av and Ar are both high.
- Load enable: ld = !Av | Ar. The output stage can accept a new byte this cycle.
- Grant:
  - One combinational grant g is chosen among the valid channels.
  - Only channel g's ready is driven, as ld. All other readies are 0.
  - When no channel is valid, all readies are 0.
- On a channel transfer:
  - A <= data(g), Sel <= g, Av <= 1.
  - The round-robin pointer ptr <= g+1 (mod 4, wraps 11 -> 00).
- On an output transfer with no channel transfer in the same cycle: Av <= 0. A and Sel hold their last values.
- Simultaneous output transfer and channel transfer: the new byte is loaded and Av stays 1. Full throughput is one byte per cycle.
- Stall (Av=1, Ar=0): ld=0, all readies 0, and A, Sel, Av, ptr all hold.
- Round-robin order: the first valid channel scanning ptr, ptr+1, ptr+2, ptr+3.
- Width: data passes through unmodified. No arithmetic is performed beyond the mod-4 pointer increment.
- Data stability: while stalled, A and Sel must not change.

## Timing
- Reset values: A=0, Sel=00, Av=0, ptr=00. Wr, Xr, Yr and Zr are 0 while rst is high.
- Latency: a byte accepted on edge n appears on A with Av=1 immediately after edge n. A value is visible to downstream one cycle after acceptance.
- Ready paths: readies depend combinationally on the valids, Av, Ar and ptr. There is no combinational path from any input data bus to any output.
- Reset mid-operation: a pending byte in the output stage is discarded, ptr returns to 00, and no handshake completes on the edge where rst is high.
- Boundary cases:
  - All four channels valid with continuous Ar=1: grants cycle 00, 01, 10, 11, 00, and so on.
  - A single valid channel is granted every cycle.

## Configuration
- MUX8_4TO1_RR_EN:
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority W > X > Y > Z. The ptr register is not implemented and grant is the lowest-code valid channel. Under sustained W traffic the other channels starve; this is accepted.

## Structure
- Shared package/header (the codebase's common lib include):
  - Sel code constants SEL_W=2'b00, SEL_X=2'b01, SEL_Y=2'b10, SEL_Z=2'b11.
  - Default WIDTH value.
  - The same codes are used by the demultiplexer so the two blocks stay in agreement.
- One sub-module, arb4_rr:
  - Inputs: 4-bit request, enable (ld), clk, rst.
  - Outputs: 2-bit grant code, grant-valid.
  - Holds ptr and implements the MUX8_4TO1_RR_EN switch.
- The top level holds the output register and the data mux.

## Test plan
1. Reset: hold rst=1 with all valids high -> A=00, Sel=00, Av=0, all readies 0. Release rst -> after the first edge, A=W's byte with Sel=00.
2. Single channel: Yv=1, Y=8'hA5, Ar=1, others idle -> Yr=1, then A=8'hA5, Sel=10, Av=1 one cycle later. Drop Yv -> Av=0 on the next edge.
3. Round-robin: all valids high, W/X/Y/Z = 11/22/33/44, Ar=1 for 5 cycles -> output sequence 11/00, 22/01, 33/10, 44/11, 11/00. Without the macro, the output is 11/00 every cycle.
4. Backpressure: the output holds 8'h22/01 and Ar=0 for 3 cycles -> A, Sel and Av are stable and all readies are 0. Ar=1 -> 8'h33/10 loads on the same edge as the output transfer.
5. Reset mid-stream: assert rst while Av=1 -> Av=0 and ptr=00 immediately. After release with all channels valid, the first grant is W.
